// File: rtl/mmio_uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package mmio_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam logic [31:0] OFF_TXDATA = 32'd0;
  localparam logic [31:0] OFF_STATUS = 32'd4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 8;

  // Even parity bit: the XOR of all data bits.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO: a push while full or a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [4:0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [4:0]       count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == 5'd0);
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 5'd0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 5'd1;
        2'b01:   count_r <= count_r - 5'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA/STATUS registers, transmit FIFO and serial framer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h810,
  parameter int          DIVISOR   = 16,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Sel,
  output logic        TxD,
  output logic        TxBusy
);

  localparam logic [15:0] CYC_LAST = 16'(DIVISOR - 1);

  tx_state_t   state_r;
  logic [15:0] cyc_r;
  logic [2:0]  bit_r;
  logic [7:0]  shift_r;
  logic        txd_r;
  logic        ovf_r;
`ifdef UART_TX_PARITY_EN
  logic        par_r;
`endif

  logic        sel_tx_s;
  logic        sel_st_s;
  logic        tx_store_s;
  logic        st_store_s;
  logic        cyc_end_s;
  logic        pop_s;
  logic        busy_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [4:0]  fifo_count_s;
  logic [7:0]  fifo_dout_s;
  logic [31:0] status_s;
  logic [31:0] rdata_s;
  logic        unused_wdata_s;

  assign sel_tx_s       = (DataAdr == (BASE_ADDR + OFF_TXDATA));
  assign sel_st_s       = (DataAdr == (BASE_ADDR + OFF_STATUS));
  assign tx_store_s     = MemWrite && sel_tx_s;
  assign st_store_s     = MemWrite && sel_st_s;
  assign cyc_end_s      = (cyc_r == CYC_LAST);
  assign busy_s         = (state_r != ST_IDLE) || !fifo_empty_s;
  assign unused_wdata_s = ^WriteData[31:8];

  assign Sel      = sel_tx_s || sel_st_s;
  assign TxD      = txd_r;
  assign TxBusy   = busy_s;
  assign ReadData = rdata_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_store_s),
    .push_data (WriteData[7:0]),
    .pop       (pop_s),
    .pop_data  (fifo_dout_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // A new frame starts from IDLE, or straight out of the last STOP cycle.
  always_comb begin
    pop_s = 1'b0;
    if (!fifo_empty_s && ((state_r == ST_IDLE) || ((state_r == ST_STOP) && cyc_end_s))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // STATUS word and read mux; TXDATA reads as zero.
  always_comb begin
    status_s                             = 32'd0;
    status_s[STAT_BUSY]                  = busy_s;
    status_s[STAT_FULL]                  = fifo_full_s;
    status_s[STAT_EMPTY]                 = fifo_empty_s;
    status_s[STAT_OVF]                   = ovf_r;
    status_s[STAT_CNT_MSB:STAT_CNT_LSB]  = fifo_count_s;
    if (MemtoReg && sel_st_s) begin
      rdata_s = status_s;
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Framer FSM and sticky overflow flag; TxD is a register so it never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cyc_r   <= 16'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      txd_r   <= 1'b1;
      ovf_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      if (tx_store_s && fifo_full_s) begin
        ovf_r <= 1'b1;
      end else if (st_store_s) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end

      if (pop_s) begin
        state_r <= ST_START;
        shift_r <= fifo_dout_s;
        txd_r   <= 1'b0;
        cyc_r   <= 16'd0;
        bit_r   <= 3'd0;
`ifdef UART_TX_PARITY_EN
        par_r   <= even_parity(fifo_dout_s);
`endif
      end else begin
        case (state_r)
          ST_IDLE: begin
            txd_r <= 1'b1;
            cyc_r <= 16'd0;
          end
          ST_START: begin
            if (cyc_end_s) begin
              state_r <= ST_DATA;
              txd_r   <= shift_r[0];
              cyc_r   <= 16'd0;
              bit_r   <= 3'd0;
            end else begin
              cyc_r <= cyc_r + 16'd1;
            end
          end
          ST_DATA: begin
            if (cyc_end_s) begin
              cyc_r <= 16'd0;
              if (bit_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_r <= ST_PARITY;
                txd_r   <= par_r;
`else
                state_r <= ST_STOP;
                txd_r   <= 1'b1;
`endif
              end else begin
                bit_r   <= bit_r + 3'd1;
                shift_r <= {1'b0, shift_r[7:1]};
                txd_r   <= shift_r[1];
              end
            end else begin
              cyc_r <= cyc_r + 16'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            if (cyc_end_s) begin
              state_r <= ST_STOP;
              txd_r   <= 1'b1;
              cyc_r   <= 16'd0;
            end else begin
              cyc_r <= cyc_r + 16'd1;
            end
          end
`endif
          ST_STOP: begin
            // Non-empty FIFO at the last STOP cycle is handled by pop_s above.
            if (cyc_end_s) begin
              state_r <= ST_IDLE;
              txd_r   <= 1'b1;
              cyc_r   <= 16'd0;
            end else begin
              cyc_r <= cyc_r + 16'd1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            txd_r   <= 1'b1;
            cyc_r   <= 16'd0;
            bit_r   <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: waveform/queue model plus directed literal checks.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h810;
  localparam logic [31:0] STAT  = 32'h814;
  localparam int          DIV   = 4;
  localparam int          DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS = 11;
  localparam logic [10:0] LIT_A5 = 11'b1_0_10100101_0;
  localparam logic [10:0] LIT_07 = 11'b1_1_00000111_0;
  localparam logic [10:0] LIT_03 = 11'b1_0_00000011_0;
`else
  localparam int          NBITS = 10;
  localparam logic [10:0] LIT_A5 = 11'b0_1_10100101_0;
  localparam logic [10:0] LIT_07 = 11'b0_1_00000111_0;
  localparam logic [10:0] LIT_03 = 11'b0_1_00000011_0;
`endif
  localparam int          FRAME = NBITS * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemtoReg = 1'b0;
  logic [31:0] DataAdr = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic [31:0] ReadData;
  logic        Sel;
  logic        TxD;
  logic        TxBusy;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR (BASE),
    .DIVISOR   (DIV),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemtoReg  (MemtoReg),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Sel       (Sel),
    .TxD       (TxD),
    .TxBusy    (TxBusy)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         cycle_cnt = 0;
  bit         chk_en = 1'b0;
  logic       line_q[$];
  logic [7:0] fifo_m[$];
  logic       ovf_m = 1'b0;
  bit         m_full;
  logic [7:0] m_byte;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cycle_cnt);
    end
  endtask

  // Line value for every cycle of one frame: start, data LSB first, [parity], stop.
  task automatic push_frame(input logic [7:0] b);
    logic v;
    for (int i = 0; i < NBITS; i++) begin
      if (i == 0) v = 1'b0;
      else if (i <= 8) v = b[i-1];
      else if (i == 9 && NBITS == 11) v = ^b;
      else v = 1'b1;
      for (int k = 0; k < DIV; k++) line_q.push_back(v);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'd0;
    s[0] = (line_q.size() > 0) || (fifo_m.size() > 0);
    s[1] = (fifo_m.size() == DEPTH);
    s[2] = (fifo_m.size() == 0);
    s[3] = ovf_m;
    s[8:4] = 5'(fifo_m.size());
    return s;
  endfunction

  // Model: advance the expected line one cycle, then apply the bus access.
  initial forever begin
    @(posedge clk);
    cycle_cnt++;
    if (reset) begin
      line_q.delete();
      fifo_m.delete();
      ovf_m = 1'b0;
    end else begin
      m_full = (fifo_m.size() == DEPTH);
      if (line_q.size() > 0) void'(line_q.pop_front());
      if (line_q.size() == 0 && fifo_m.size() > 0) begin
        m_byte = fifo_m.pop_front();
        push_frame(m_byte);
      end
      if (MemWrite && DataAdr == BASE) begin
        if (m_full) ovf_m = 1'b1;
        else fifo_m.push_back(WriteData[7:0]);
      end else if (MemWrite && DataAdr == STAT) begin
        ovf_m = 1'b0;
      end
    end
  end

  // Cycle-by-cycle compare of the serial line and busy flag.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("txd", {31'd0, TxD}, {31'd0, (line_q.size() > 0) ? line_q[0] : 1'b1});
      chk("busy", {31'd0, TxBusy}, {31'd0, (line_q.size() > 0) || (fifo_m.size() > 0)});
    end
  end

  task automatic cyc(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    MemWrite = we; DataAdr = adr; WriteData = wd;
    @(negedge clk);
    MemWrite = 1'b0; MemtoReg = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
  endtask

  task automatic rd(input string nm, input logic [31:0] adr, input logic exp_sel,
                    input logic [31:0] lit, input bit use_lit);
    MemtoReg = 1'b1; DataAdr = adr;
    #1;
    chk({nm, "_sel"}, {31'd0, Sel}, {31'd0, exp_sel});
    if (adr == STAT) chk(nm, ReadData, exp_status());
    else chk(nm, ReadData, 32'd0);
    if (use_lit) chk({nm, "_lit"}, ReadData, lit);
    @(negedge clk);
    MemtoReg = 1'b0; DataAdr = 32'd0;
  endtask

  task automatic wait_idle(input string nm, input int limit, output int n);
    n = 0;
    while (TxBusy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk({nm, "_timeout"}, {31'd0, TxBusy}, 32'd0);
  endtask

  task automatic send_frame(input string nm, input logic [7:0] b, input logic [10:0] lit);
    cyc(1'b1, BASE, {24'hFFFFFF, b});
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      chk($sformatf("%s_slot%0d", nm, k / DIV), {31'd0, TxD}, {31'd0, lit[k / DIV]});
    end
    @(negedge clk);
    chk({nm, "_done"}, {31'd0, TxBusy}, 32'd0);
  endtask

  initial begin
    int t0;
    int n;
    int zeros;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_txd", {31'd0, TxD}, 32'd1);
    chk("rst_busy", {31'd0, TxBusy}, 32'd0);
    rd("rst_status", STAT, 1'b1, 32'h004, 1'b1);

    send_frame("a5", 8'hA5, LIT_A5);

    // Fill the FIFO, overflow it, then clear the overflow flag.
    t0 = cycle_cnt;
    for (int i = 0; i < 5; i++) cyc(1'b1, BASE, 32'h11 * (i + 1));
    rd("st_full", STAT, 1'b1, 32'h043, 1'b1);
    cyc(1'b1, BASE, 32'h66);
    rd("st_ovf", STAT, 1'b1, 32'h04B, 1'b1);
    cyc(1'b1, STAT, 32'hDEAD_BEEF);
    rd("st_clr", STAT, 1'b1, 32'h043, 1'b1);
    wait_idle("b2b", 1000, n);
    chk("b2b_len", cycle_cnt - t0, 2 + 5 * FRAME);

    // Abort a frame with reset during data bit 3.
    cyc(1'b1, BASE, 32'h5A);
    repeat (18) @(negedge clk);
    chk("mid_bit3", {31'd0, TxD}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_txd", {31'd0, TxD}, 32'd1);
    chk("abort_busy", {31'd0, TxBusy}, 32'd0);
    rd("abort_status", STAT, 1'b1, 32'h004, 1'b1);
    zeros = 0;
    repeat (50) begin
      @(negedge clk);
      if (TxD === 1'b0) zeros++;
    end
    chk("abort_quiet", zeros, 0);

    rd("sel_status", STAT, 1'b1, 32'h004, 1'b1);
    rd("sel_other", 32'h800, 1'b0, 32'd0, 1'b1);
    rd("sel_txdata", BASE, 1'b1, 32'd0, 1'b1);

    send_frame("b07", 8'h07, LIT_07);
    send_frame("b03", 8'h03, LIT_03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
